// File: rtl/systolic_fpga_example_axi_mem_responder.sv
// AXI4 slave memory responder (AW/W/B/AR/R, INCR bursts, no IDs/resp) backed by on-chip RAM.
// Optional wlast consistency monitor enabled by defining AXI_MEM_RESP_WLAST_CHECK_EN.
module systolic_fpga_example_axi_mem_responder #(
    parameter int C_S_AXI_ADDR_WIDTH = 64,
    parameter int C_S_AXI_DATA_WIDTH = 512,
    parameter int C_MEM_DEPTH_LOG2   = 10
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                            s_axi_rlast
`ifdef AXI_MEM_RESP_WLAST_CHECK_EN
    ,
    output logic                            err_wlast
`endif
);

    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int DEPTH  = 1 << C_MEM_DEPTH_LOG2;

    typedef logic [C_MEM_DEPTH_LOG2-1:0] idx_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t   w_state;
    idx_t       w_idx;
    logic [8:0] w_count;

    r_state_t   r_state;
    idx_t       r_idx;
    logic [7:0] r_rem;

    logic w_fire;
    logic ar_fire;
    logic r_fire;
    idx_t aw_idx;
    idx_t ar_idx;

    assign w_fire  = s_axi_wvalid  && s_axi_wready;
    assign ar_fire = s_axi_arvalid && s_axi_arready;
    assign r_fire  = s_axi_rvalid  && s_axi_rready;
    assign aw_idx  = s_axi_awaddr[OFFS +: C_MEM_DEPTH_LOG2];
    assign ar_idx  = s_axi_araddr[OFFS +: C_MEM_DEPTH_LOG2];

    // Byte offset and upper address bits select nothing; wlast only feeds the optional monitor.
    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi_awaddr, s_axi_araddr, s_axi_wlast};

    // NOTE: the RAM array sits outside the reset domain on purpose; resetting it would
    // prevent block-RAM mapping, and its contents are defined only once written.
    always_ff @(posedge aclk) begin
        if (w_fire) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state       <= W_IDLE;
            w_idx         <= '0;
            w_count       <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    s_axi_awready <= 1'b1;
                    if (s_axi_awvalid && s_axi_awready) begin
                        w_idx         <= aw_idx;
                        w_count       <= {1'b0, s_axi_awlen} + 9'd1;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    // Burst length comes from the beat counter, never from wlast.
                    if (w_fire) begin
                        w_idx   <= w_idx + idx_t'(1);
                        w_count <= w_count - 9'd1;
                        if (w_count == 9'd1) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // NOTE: rdata samples mem with a non-blocking read in the same edge a write may land,
    // so a colliding read sees the pre-write word.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state       <= R_IDLE;
            r_idx         <= '0;
            r_rem         <= '0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (ar_fire) begin
                        s_axi_arready <= 1'b0;
                        s_axi_rdata   <= mem[ar_idx];
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rlast   <= (s_axi_arlen == 8'd0);
                        r_idx         <= ar_idx + idx_t'(1);
                        r_rem         <= s_axi_arlen;
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            s_axi_rdata <= mem[r_idx];
                            s_axi_rlast <= (r_rem == 8'd1);
                            r_idx       <= r_idx + idx_t'(1);
                            r_rem       <= r_rem - 8'd1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

`ifdef AXI_MEM_RESP_WLAST_CHECK_EN
    // Sticky flag: wlast must be high exactly on the beat the counter marks as final.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_wlast <= 1'b0;
        end else if (w_fire && (s_axi_wlast != (w_count == 9'd1))) begin
            err_wlast <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_fpga_example_axi_mem_responder.sv
// Self-checking bench for the AXI4 memory responder: vector table, directed corner cases,
// and randomized bursts scored against a word-array memory model.
module tb_systolic_fpga_example_axi_mem_responder;

    localparam int AW    = 64;
    localparam int DW    = 32;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;
    localparam int BPW   = DW / 8;

    logic            aclk = 1'b0;
    logic            areset;
    logic            awvalid, awready;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic            wvalid, wready;
    logic [DW-1:0]   wdata;
    logic [BPW-1:0]  wstrb;
    logic            wlast;
    logic            bvalid, bready;
    logic            arvalid, arready;
    logic [AW-1:0]   araddr;
    logic [7:0]      arlen;
    logic            rvalid, rready;
    logic [DW-1:0]   rdata;
    logic            rlast;
`ifdef AXI_MEM_RESP_WLAST_CHECK_EN
    logic            err_wlast;
`endif

    systolic_fpga_example_axi_mem_responder #(
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_S_AXI_DATA_WIDTH(DW),
        .C_MEM_DEPTH_LOG2  (DL2)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_awaddr (awaddr),
        .s_axi_awlen  (awlen),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_wlast  (wlast),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_araddr (araddr),
        .s_axi_arlen  (arlen),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .s_axi_rdata  (rdata),
        .s_axi_rlast  (rlast)
`ifdef AXI_MEM_RESP_WLAST_CHECK_EN
        ,
        .err_wlast    (err_wlast)
`endif
    );

    always #5 aclk = ~aclk;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0]  model_mem   [DEPTH];
    logic [DW-1:0]  wr_data     [256];
    logic [BPW-1:0] wr_strb     [256];
    logic [DW-1:0]  rd_captured [256];

    typedef struct {
        logic [AW-1:0]  addr;
        logic [DW-1:0]  pre;
        logic [DW-1:0]  data;
        logic [BPW-1:0] strb;
        logic [DW-1:0]  exp;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic timeout_fail(input string nm);
        n_total++;
        $display("FAIL %s: got timeout expected handshake", nm);
    endtask

    // Word index as the byte address divided by the word size, modulo the RAM depth.
    function automatic int widx(input logic [AW-1:0] a);
        return int'((a / BPW) % DEPTH);
    endfunction

    function automatic void model_write(input int idx, input logic [DW-1:0] d, input logic [BPW-1:0] s);
        for (int b = 0; b < BPW; b++)
            if (s[b]) model_mem[idx % DEPTH][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic axi_write(input logic [AW-1:0] addr, input int beats, input int bdelay,
                             input bit gaps, input int wl_at);
        int cyc;
        int base;
        base    = widx(addr);
        awaddr  = addr;
        awlen   = 8'(beats - 1);
        awvalid = 1'b1;
        cyc     = 0;
        while (!awready && cyc < 50) begin @(posedge aclk); #1; cyc++; end
        if (!awready) begin
            timeout_fail("aw_wait");
            awvalid = 1'b0;
            return;
        end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        check("wready_after_aw", wready, 1);
        for (int i = 0; i < beats; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(posedge aclk); #1;
            end
            wvalid = 1'b1;
            wdata  = wr_data[i];
            wstrb  = wr_strb[i];
            wlast  = (i == wl_at);
            @(posedge aclk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        check("bvalid_latency", bvalid, 1);
        check("wready_done", wready, 0);
        for (int d = 0; d < bdelay; d++) begin
            @(posedge aclk); #1;
            check("bvalid_hold", bvalid, 1);
            check("awready_hold", awready, 0);
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        check("bvalid_clear", bvalid, 0);
        check("awready_back", awready, 1);
        for (int i = 0; i < beats; i++) model_write(base + i, wr_data[i], wr_strb[i]);
    endtask

    // mode 0: rready always high; 1: pattern 1,0,0 repeating; 2: random
    task automatic axi_read(input logic [AW-1:0] addr, input int beats, input int mode);
        int cyc;
        int got;
        int base;
        base    = widx(addr);
        araddr  = addr;
        arlen   = 8'(beats - 1);
        arvalid = 1'b1;
        cyc     = 0;
        while (!arready && cyc < 50) begin @(posedge aclk); #1; cyc++; end
        if (!arready) begin
            timeout_fail("ar_wait");
            arvalid = 1'b0;
            return;
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        check("rvalid_latency", rvalid, 1);
        got = 0;
        cyc = 0;
        while (got < beats) begin
            if (cyc >= 4000) begin timeout_fail("r_beats"); break; end
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (cyc % 3 == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            check("rvalid_in_burst", rvalid, 1);
            if (rvalid) begin
                check("rdata", rdata, model_mem[(base + got) % DEPTH]);
                check("rlast", rlast, (got == beats - 1));
                if (rready) begin
                    rd_captured[got] = rdata;
                    got++;
                end
            end
            @(posedge aclk); #1;
            cyc++;
        end
        rready = 1'b0;
        check("rvalid_end", rvalid, 0);
        check("arready_end", arready, 1);
    endtask

    task automatic pulse_reset();
        #2 areset = 1'b1;
        #1;
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_wready",  wready,  0);
        check("rst_bvalid",  bvalid,  0);
        check("rst_rvalid",  rvalid,  0);
        check("rst_rlast",   rlast,   0);
        check("rst_rdata",   rdata,   0);
        awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        rready = 1'b0; bready = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk); #1;
        check("post_rst_awready", awready, 1);
        check("post_rst_arready", arready, 1);
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp4 [4];
        logic [AW-1:0] ra;
        int            nb;

        tbl[0] = '{addr: 64'h14,                  pre: 32'hFFFF_FFFF, data: 32'h0000_00A5, strb: 4'b0001, exp: 32'hFFFF_FFA5};
        tbl[1] = '{addr: 64'h17,                  pre: 32'h1234_5678, data: 32'hAABB_CCDD, strb: 4'b1010, exp: 32'hAA34_CC78};
        tbl[2] = '{addr: 64'hF000_0000_0000_0008, pre: 32'h0000_0000, data: 32'hFFFF_FFFF, strb: 4'b0000, exp: 32'h0000_0000};
        tbl[3] = '{addr: 64'h3C,                  pre: 32'h0000_0000, data: 32'hCAFE_F00D, strb: 4'b1111, exp: 32'hCAFE_F00D};
        tbl[4] = '{addr: 64'h44,                  pre: 32'h5555_5555, data: 32'h0000_AA00, strb: 4'b0010, exp: 32'h5555_AA55};

        areset = 1'b1;
        awvalid = 1'b0; awaddr = '0; awlen = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; araddr = '0; arlen = '0; rready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("reset_awready", awready, 0);
        check("reset_arready", arready, 0);
        check("reset_wready",  wready,  0);
        check("reset_bvalid",  bvalid,  0);
        check("reset_rvalid",  rvalid,  0);
        check("reset_rlast",   rlast,   0);
        check("reset_rdata",   rdata,   0);
`ifdef AXI_MEM_RESP_WLAST_CHECK_EN
        check("reset_err_wlast", err_wlast, 0);
`endif
        areset = 1'b0;
        @(posedge aclk); #1;
        check("first_cycle_awready", awready, 1);
        check("first_cycle_arready", arready, 1);

        // Fill every word so later reads compare against defined contents.
        for (int i = 0; i < DEPTH; i++) begin wr_data[i] = $urandom(); wr_strb[i] = '1; end
        axi_write(64'h0, DEPTH, 0, 0, DEPTH - 1);

        // Basic 4-beat write then read back, with B held off for 5 cycles.
        exp4 = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) begin wr_data[i] = exp4[i]; wr_strb[i] = '1; end
        axi_write(64'h0, 4, 5, 0, 3);
        axi_read(64'h0, 4, 0);
        for (int i = 0; i < 4; i++) check("basic_readback", rd_captured[i], exp4[i]);

        // Vector table: preload, partial-strobe write, single-beat readback.
        for (int v = 0; v < 5; v++) begin
            wr_data[0] = tbl[v].pre;  wr_strb[0] = '1;
            axi_write(tbl[v].addr, 1, 0, 0, 0);
            wr_data[0] = tbl[v].data; wr_strb[0] = tbl[v].strb;
            axi_write(tbl[v].addr, 1, 0, 0, 0);
            axi_read(tbl[v].addr, 1, 0);
            check("table_readback", rd_captured[0], tbl[v].exp);
        end

        // Read backpressure with rready 1,0,0,... over an 8-beat burst.
        axi_read(64'h0, 8, 1);

        // Wrap: 4 beats from word 14 land at 14, 15, 0, 1.
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA0 + 32'(i); wr_strb[i] = '1; end
        axi_write(64'h38, 4, 0, 0, 3);
        axi_read(64'h38, 1, 0); check("wrap_w14", rd_captured[0], 32'hA0);
        axi_read(64'h3C, 1, 0); check("wrap_w15", rd_captured[0], 32'hA1);
        axi_read(64'h00, 1, 0); check("wrap_w0",  rd_captured[0], 32'hA2);
        axi_read(64'h04, 1, 0); check("wrap_w1",  rd_captured[0], 32'hA3);

        // 256-beat burst starting at the last word.
        for (int i = 0; i < 256; i++) begin wr_data[i] = $urandom(); wr_strb[i] = 4'($urandom()); end
        axi_write(64'h3C, 256, 1, 1, 255);
        axi_read(64'h3C, 256, 2);

        // Same-cycle read and write of word 3: read returns the old value.
        wr_data[0] = 32'h1234_5678; wr_strb[0] = '1;
        axi_write(64'hC, 1, 0, 0, 0);
        awaddr = 64'hC; awlen = 8'd0; awvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        check("coll_wready", wready, 1);
        check("coll_arready", arready, 1);
        wvalid = 1'b1; wdata = 32'h0000_BEEF; wstrb = '1; wlast = 1'b1;
        arvalid = 1'b1; araddr = 64'hC; arlen = 8'd0;
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        check("coll_rvalid", rvalid, 1);
        check("coll_old_data", rdata, 32'h1234_5678);
        check("coll_rlast", rlast, 1);
        check("coll_bvalid", bvalid, 1);
        rready = 1'b1; bready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0; bready = 1'b0;
        model_write(3, 32'h0000_BEEF, '1);
        axi_read(64'hC, 1, 0);
        check("coll_new_data", rd_captured[0], 32'h0000_BEEF);

        // Reset during beat 2 of an 8-beat read.
        araddr = 64'h0; arlen = 8'd7; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        check("midread_beat2_valid", rvalid, 1);
        check("midread_beat2_data", rdata, model_mem[1]);
        pulse_reset();

        // Reset after 2 of 4 write beats: no B response, the two beats stay written.
        awaddr = 64'h20; awlen = 8'd3; awvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1; wdata = 32'hD00D_0000 + 32'(i); wstrb = '1; wlast = 1'b0;
            @(posedge aclk); #1;
            model_write(8 + i, 32'hD00D_0000 + 32'(i), '1);
        end
        wvalid = 1'b0;
        pulse_reset();
        repeat (3) begin
            @(posedge aclk); #1;
            check("no_b_after_reset", bvalid, 0);
        end
        axi_read(64'h20, 4, 0);

        // Randomized bursts against the model.
        for (int t = 0; t < 20; t++) begin
            ra = {$urandom(), $urandom()};
            nb = ($urandom_range(0, 9) == 0) ? 256 : $urandom_range(1, 20);
            for (int i = 0; i < nb; i++) begin wr_data[i] = $urandom(); wr_strb[i] = 4'($urandom()); end
            axi_write(ra, nb, $urandom_range(0, 3), 1, nb - 1);
            ra = {$urandom(), $urandom()};
            axi_read(ra, $urandom_range(1, 24), $urandom_range(0, 2));
        end

`ifdef AXI_MEM_RESP_WLAST_CHECK_EN
        check("err_wlast_clean", err_wlast, 0);
        for (int i = 0; i < 4; i++) begin wr_data[i] = $urandom(); wr_strb[i] = '1; end
        axi_write(64'h20, 4, 0, 0, 1);
        check("err_wlast_set", err_wlast, 1);
        axi_read(64'h20, 4, 0);
        check("err_wlast_sticky", err_wlast, 1);
        pulse_reset();
        check("err_wlast_cleared", err_wlast, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
